// File: rtl/chip8_pkg.sv
// Shared constants for the chip8 sound path: system clock rate and beeper state encoding.
package chip8_pkg;

    localparam int unsigned CLK_HZ = 100_000_000;

    localparam logic [1:0] BEEP_IDLE   = 2'd0;
    localparam logic [1:0] BEEP_PLAY   = 2'd1;
    localparam logic [1:0] BEEP_FINISH = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE   = BEEP_IDLE,
        ST_PLAY   = BEEP_PLAY,
        ST_FINISH = BEEP_FINISH
    } beep_state_e;

endpackage

// File: rtl/tone_divider.sv
// Half-period divider: counts 0..HALF_PERIOD-1, flags the terminal count and wraps.
module tone_divider #(
    parameter int HALF_PERIOD = 113636,
    parameter int CNT_W       = 17
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    output logic o_tc
);

    localparam logic [CNT_W-1:0] LP_TC_VAL = CNT_W'(HALF_PERIOD - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr || o_tc) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_tc = (r_cnt == LP_TC_VAL);

endmodule

// File: rtl/beeper.sv
// Square-wave beeper: plays while the sound timer is non-zero and unmuted, and only
// stops at the end of a high half-period so no shortened pulse reaches the speaker.
module beeper
    import chip8_pkg::*;
#(
    parameter int HALF_PERIOD = int'(CLK_HZ / (2 * 440)),
    parameter int CNT_W       = 17
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] sound_timer,
    input  logic       mute,
    output logic       audio,
    output logic       sound_active,
    output logic [1:0] dbg_state
);

    beep_state_e r_state;
    beep_state_e w_state_nxt;
    logic        r_audio;
    logic        w_audio_nxt;
    logic        w_req;
    logic        w_clr;
    logic        w_tc;

    assign w_req = (sound_timer != 8'd0) && !mute;

    tone_divider #(
        .HALF_PERIOD (HALF_PERIOD),
        .CNT_W       (CNT_W)
    ) u_div (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (w_clr),
        .o_tc  (w_tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_audio <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_audio <= w_audio_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_audio_nxt = r_audio;
        w_clr       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_clr       = 1'b1;
                w_audio_nxt = 1'b0;
                if (w_req) begin
                    w_state_nxt = ST_PLAY;
                    w_audio_nxt = 1'b1;
                end
            end
            ST_PLAY: begin
                if (!w_req) begin
                    // A request drop during the high phase must let the pulse finish.
                    if (!r_audio) begin
                        w_state_nxt = ST_IDLE;
                        w_clr       = 1'b1;
                        w_audio_nxt = 1'b0;
                    end else if (w_tc) begin
                        w_state_nxt = ST_IDLE;
                        w_audio_nxt = 1'b0;
                    end else begin
                        w_state_nxt = ST_FINISH;
                    end
                end else if (w_tc) begin
                    w_audio_nxt = ~r_audio;
                end
            end
            ST_FINISH: begin
                if (w_tc) begin
                    w_state_nxt = ST_IDLE;
                    w_audio_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_audio_nxt = 1'b0;
                w_clr       = 1'b1;
            end
        endcase
    end

    assign audio        = r_audio;
    assign sound_active = (r_state != ST_IDLE);
    assign dbg_state    = r_state;

endmodule

// File: doc/beeper.md
# beeper

Tone generator that consumes the 8-bit sound timer and drives the buzzer output. While the sound timer is non-zero and not muted, it emits a fixed-frequency 50 % square wave; when the timer expires, it stops only on a period boundary, so no runt high pulse ever reaches the speaker. It sits between the timer block and the board's audio pin.

## Interface
- `HALF_PERIOD`, default 113636: clock cycles per half tone period (100 MHz / (2 × 440 Hz)); legal range is 2 to 2^17.
- `CNT_W`, default 17: divider counter width; must satisfy 2^CNT_W ≥ `HALF_PERIOD`.
- `clk` in, 1 bit: system clock, 100 MHz.
- `rst_n` in, 1 bit: reset, asynchronous and active-low.
- `sound_timer` in, 8 bits: current sound-timer value; non-zero requests tone.
- `mute` in, 1 bit: when high, suppresses the tone request.
- `audio` out, 1 bit: square-wave drive to the buzzer.
- `sound_active` out, 1 bit: high whenever the state is not IDLE.

## Operation
- Request: `req = (sound_timer != 0) && !mute`, sampled each rising `clk`.
- Divider: `cnt` is `CNT_W` bits, counting 0 to `HALF_PERIOD-1`. The terminal count is `tc = (cnt == HALF_PERIOD-1)`. At `tc`, `cnt` wraps to 0 and `audio` toggles.
- States are IDLE, PLAY and FINISH.
- IDLE:
  - `cnt` is held at 0 and `audio` is 0.
  - If `req`: go to PLAY, set `audio` to 1, set `cnt` to 0.
- PLAY: the divider runs. If `!req`:
  - `audio==0`: go to IDLE and clear `cnt`.
  - `audio==1` and `tc`: `audio` goes to 0, go to IDLE.
  - `audio==1` and not `tc`: go to FINISH and keep counting.
- FINISH:
  - The divider keeps running and `req` is ignored.
  - At `tc`, `audio` goes to 0 and the state goes to IDLE.
  - A new request is honoured from IDLE on the following cycle.
- `sound_active` is `(state != IDLE)`, decoded from the state register.
- Reset, asynchronous on `rst_n` low:
  - State goes to IDLE; `cnt`, `audio` and `sound_active` go to 0.
  - A reset mid-tone truncates the pulse immediately. This is the only permitted runt.
- `mute` asserted mid-tone behaves exactly like the timer expiring.
- `sound_timer` changing between non-zero values has no effect on phase.

## Timing
- Start latency: 1 cycle. `req` seen at edge N gives `audio=1` after edge N.
- Every high pulse lasts exactly `HALF_PERIOD` cycles, except when reset intervenes.
- Low phases between pulses are exactly `HALF_PERIOD` cycles while in PLAY.
- Stop latency:
  - In the low phase: 1 cycle to IDLE.
  - In the high phase: at most `HALF_PERIOD` cycles; `audio` falls on the natural toggle.
- Minimum idle gap after FINISH before a restart: 1 cycle (the IDLE cycle).
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package `chip8_pkg` holds:
  - `CLK_HZ = 100_000_000`, so timers and beeper share one constant.
  - State encoding localparams `BEEP_IDLE = 2'd0`, `BEEP_PLAY = 2'd1`, `BEEP_FINISH = 2'd2`.
  - `2'd3` is illegal and recovers to IDLE.
- A `tone_divider` sub-module (counter plus `tc` output, with a synchronous clear input) is natural. The FSM and `audio` register stay in `beeper`.

## Test plan
All scenarios use `HALF_PERIOD=4`.
- **Reset:** hold `rst_n=0` with `sound_timer=8'd5` → `audio=0`, `sound_active=0`. Release → `audio=1` one edge later.
- **Steady tone:** `sound_timer=8'd3`, `mute=0` for 40 cycles → `audio` follows the pattern 4 high / 4 low repeatedly; `sound_active=1` throughout.
- **Stop mid-high:** drop `sound_timer` to 0 on the 2nd high cycle → `audio` stays high for exactly 4 cycles total, then 0; `sound_active` falls on the same edge as `audio`.
- **Stop during low:** drop to 0 during the low phase → IDLE after 1 edge; `audio` stays 0 with no extra pulse.
- **Mute and restart:**
  - Pulse `mute=1` for 1 cycle mid-high → the pulse completes at 4 cycles, then IDLE for 1 cycle.
  - With `sound_timer` still at 2, `audio` rises again on the next edge.
- **Async reset mid-tone:** drive `rst_n=0` between clock edges while `audio=1` → `audio=0` and `sound_active=0` immediately, without waiting for a clock edge.
